// File: rtl/b2c_4bit_pkg.sv
// b2c_4bit_pkg: shared constants for the binary-to-two's-complement converter.
//   B2cWidth : default operand width (the block is verified at this width).
package b2c_4bit_pkg;

  localparam int unsigned B2cWidth = 4;

endpackage : b2c_4bit_pkg

// File: rtl/b2c_4bit_core.sv
// b2c_4bit_core: combinational negate/pass-through core.
//   i_b     : operand
//   i_conv  : 1 = two's complement of i_b, 0 = pass i_b through
//   o_r     : result, (~i_b + 1) mod 2^WIDTH when converting, else i_b
//   o_ovf   : converting the most-negative code (1 followed by zeros)
module b2c_4bit_core
  import b2c_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = B2cWidth
) (
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_conv,
  output logic [WIDTH-1:0] o_r,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  assign w_inv      = ~i_b;
  // Incrementer: carry-in of 1 rippled through the inverted operand. The
  // carry out of the top bit is the mod-2^WIDTH wrap and is never formed.
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < WIDTH; g++) begin : g_inc
    assign w_sum[g] = w_inv[g] ^ w_carry[g];
    if (g < WIDTH - 1) begin : g_carry
      assign w_carry[g+1] = w_inv[g] & w_carry[g];
    end
  end

  assign o_r   = i_conv ? w_sum : i_b;
  assign o_ovf = i_conv & i_b[WIDTH-1] & ~|i_b[WIDTH-2:0];

endmodule : b2c_4bit_core

// File: rtl/b2c_4bit.sv
// b2c_4bit: registered binary-to-two's-complement converter, 1-cycle latency.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : B and conv are sampled this cycle
//   conv      : 1 = output two's complement of B, 0 = pass B through
//   B         : operand
//   X         : registered result (holds when in_valid is low)
//   out_valid : X and ovf are valid this cycle
//   ovf       : negation of the most-negative code is not representable
module b2c_4bit
  import b2c_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = B2cWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             conv,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] X,
  output logic             out_valid,
  output logic             ovf
);

  logic [WIDTH-1:0] w_r;
  logic             w_ovf;

  logic [WIDTH-1:0] r_x;
  logic             r_ovf;
  logic             r_valid;

  b2c_4bit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_b    (B),
    .i_conv (conv),
    .o_r    (w_r),
    .o_ovf  (w_ovf)
  );

  // Data and flag only load on a valid cycle; valid itself follows in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_x   <= w_r;
        r_ovf <= w_ovf;
      end
    end
  end

  assign X         = r_x;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule : b2c_4bit

// File: tb/tb_b2c_4bit.sv
// tb_b2c_4bit: self-checking bench for b2c_4bit (directed table, sweeps,
// involution, randomized run against an arithmetic reference model).
module tb_b2c_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       conv;
  logic [3:0] B;
  logic [3:0] X;
  logic       out_valid;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the outputs should read after each edge.
  int m_x;
  int m_valid;
  int m_ovf;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       conv;
    logic [3:0] b;
    logic [3:0] exp_x;
    logic       exp_v;
    logic       exp_o;
  } vec_t;

  vec_t vecs[10];

  b2c_4bit #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .conv      (conv),
    .B         (B),
    .X         (X),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d exp=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Apply inputs, clock once, update the model, sample 1 time unit later.
  task automatic step(input logic r, input logic iv, input logic cv, input logic [3:0] b);
    rst      = r;
    in_valid = iv;
    conv     = cv;
    B        = b;
    @(posedge clk);
    #1;
    if (r) begin
      m_x = 0; m_valid = 0; m_ovf = 0;
    end else begin
      m_valid = iv ? 1 : 0;
      if (iv) begin
        m_x   = cv ? (16 - int'(b)) % 16 : int'(b);
        m_ovf = (cv && b == 4'd8) ? 1 : 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"},     int'(X),         m_x);
    check({tag, ".valid"}, int'(out_valid), m_valid);
    check({tag, ".ovf"},   int'(ovf),       m_ovf);
  endtask

  initial begin
    logic [3:0] x_first;
    rst = 1'b1; in_valid = 1'b0; conv = 1'b0; B = 4'd0;
    m_x = 0; m_valid = 0; m_ovf = 0;

    // rst, iv, conv, B -> X, out_valid, ovf
    vecs[0] = '{1'b1, 1'b1, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'b0011, 4'b1101, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'b0111, 4'b1101, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'b0010, 4'b1110, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 4'b0001, 4'b1000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].conv, vecs[i].b);
      check($sformatf("vec%0d.x", i),     int'(X),         int'(vecs[i].exp_x));
      check($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].exp_v));
      check($sformatf("vec%0d.ovf", i),   int'(ovf),       int'(vecs[i].exp_o));
    end

    // Back-to-back negate sweep, then pass-through sweep.
    for (int b = 0; b < 16; b++) begin
      step(1'b0, 1'b1, 1'b1, 4'(b));
      check_model($sformatf("neg%0d", b));
    end
    for (int b = 0; b < 16; b++) begin
      step(1'b0, 1'b1, 1'b0, 4'(b));
      check_model($sformatf("pass%0d", b));
    end

    // Involution: negate, feed the result back, expect the original code.
    for (int b = 0; b < 16; b++) begin
      step(1'b0, 1'b1, 1'b1, 4'(b));
      check_model($sformatf("inv_a%0d", b));
      x_first = X;
      step(1'b0, 1'b1, 1'b1, x_first);
      check($sformatf("inv_b%0d", b), int'(X), b);
    end

    // Randomized traffic with occasional resets and idle cycles.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0),
           1'($urandom_range(1)), 4'($urandom_range(15)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_b2c_4bit

// File: doc/b2c_4bit.md
Name: b2c_4bit

Overview:
- Registered 4-bit binary-to-two's-complement converter (negator) used by the MACC multiplier to convert operands between magnitude and signed form.
- Takes a 4-bit input B and produces X = (~B + 1) mod 16 when conversion is requested; otherwise passes B through unchanged.
- One-cycle registered latency with a valid strobe and an overflow flag for the non-negatable code 4'b1000.

Parameters:
- WIDTH, 4, data width of B and X. Legal values are WIDTH >= 2; the block is verified at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  B and conv are sampled this cycle
- conv  input  1  1 = output two's complement of B; 0 = pass B through
- B  input  WIDTH  binary input operand
- X  output  WIDTH  registered result
- out_valid  output  1  X and ovf are valid this cycle
- ovf  output  1  high when conv=1 and B = 1 followed by all zeros (4'b1000 at WIDTH=4); negation is not representable in this case

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a clk edge with rst=1, X=0, out_valid=0 and ovf=0. Reset overrides in_valid on the same edge.
- Arithmetic, combinational core:
  - conv=1: R = (~B + 1) truncated to WIDTH bits; the carry-out is discarded.
  - conv=0: R = B.
  - Required values at WIDTH=4 with conv=1:
    - 0000->0000, 0001->1111, 0010->1110, 0011->1101
    - 0100->1100, 0101->1011, 0110->1010, 0111->1001
    - 1000->1000 with ovf=1
    - 1001->0111, 1010->0110, 1011->0101, 1100->0100
    - 1101->0011, 1110->0010, 1111->0001
- Overflow:
  - ovf = conv & B[WIDTH-1] & ~|B[WIDTH-2:0].
  - B=0 with conv=1 gives X=0 and ovf=0.
- Latency: exactly 1 cycle.
  - On a clk edge with rst=0 and in_valid=1: X<=R, ovf<=ovf_comb, out_valid<=1.
  - On a clk edge with rst=0 and in_valid=0: out_valid<=0; X and ovf hold their previous values.
- Throughput: one conversion per cycle. There is no backpressure; back-to-back in_valid produces back-to-back out_valid.
- Involution: converting X again with conv=1 returns the original B for every B.
- Reset mid-stream: an operation in flight is discarded; out_valid is 0 on the cycle after reset.
- No X/Z propagation from inputs is required when in_valid=0.

Decomposition:
- No shared package is needed; WIDTH is the only constant.
- One natural sub-module: b2c_core, purely combinational. It takes (B, conv) and returns (R, ovf_comb), implemented as an inverter stage plus an incrementer or ripple carry chain.
- The top level, b2c_4bit, holds the output registers and the valid/reset logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, B=4'b0101 -> X=0000, out_valid=0, ovf=0 throughout.
- Exhaustive negate: conv=1, in_valid=1, B swept 0000..1111 on consecutive cycles -> each X matches the table one cycle later (e.g. 0001->1111, 0110->1010, 1111->0001); out_valid stays 1; ovf=1 only for B=1000.
- Pass-through: conv=0, B swept 0000..1111 -> X=B one cycle later; ovf=0 for all, including B=1000.
- Valid gating: drive B=0011 with in_valid=1, then B=0111 with in_valid=0 -> X=1101 is held and out_valid drops to 0 on the second cycle.
- Involution: feed each X back as B with conv=1 -> the original value is recovered for all 16 codes.
- Reset mid-stream: in_valid=1, B=0010, then rst=1 for one cycle -> next cycle X=0000, out_valid=0; normal operation resumes after rst deasserts.
